// File: rtl/rtsnoc_echo_tester.sv
// Echo-node traffic generator and checker for an RTSNoC router local port.
// Sends NUM_PKTS single-flit packets, waits for each reply and checks payload plus swapped header.
module rtsnoc_echo_tester #(
   parameter int                          SOC_SIZE_X     = 1,
   parameter int                          SOC_SIZE_Y     = 1,
   parameter int                          NOC_DATA_WIDTH = 16,
   parameter int                          MY_X           = 0,
   parameter int                          MY_Y           = 0,
   parameter logic [2:0]                  MY_LOCAL       = 3'd0,
   parameter int                          ECHO_X         = 0,
   parameter int                          ECHO_Y         = 0,
   parameter logic [2:0]                  ECHO_LOCAL     = 3'd1,
   parameter int                          NUM_PKTS       = 16,
   parameter logic [NOC_DATA_WIDTH-1:0]   SEED           = 'h00A5,
   parameter int                          TIMEOUT        = 255,
   localparam int                         HDR            = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6,
   localparam int                         B              = NOC_DATA_WIDTH + HDR
) (
   input  logic         clk_i,
   input  logic         rst_i,
   output logic [B-1:0] din_o,
   output logic         wr_o,
   input  logic [B-1:0] dout_i,
   input  logic         nd_i,
   output logic         rd_o,
   input  logic         wait_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         pass_o,
   output logic [7:0]   err_count_o,
   output logic [7:0]   timeout_count_o
);

   localparam int W  = NOC_DATA_WIDTH;
   localparam int AW = SOC_SIZE_X + SOC_SIZE_Y + 3;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [AW-1:0] MY_ADDR   = {SOC_SIZE_X'(MY_X), SOC_SIZE_Y'(MY_Y), MY_LOCAL};
   localparam logic [AW-1:0] ECHO_ADDR = {SOC_SIZE_X'(ECHO_X), SOC_SIZE_Y'(ECHO_Y), ECHO_LOCAL};
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [W-1:0]  SEQ_LAST   = W'(NUM_PKTS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SEND_WAIT = 3'd1;
   localparam logic [2:0] S_SEND      = 3'd2;
   localparam logic [2:0] S_RECV      = 3'd3;
   localparam logic [2:0] S_CHECK     = 3'd4;
   localparam logic [2:0] S_NEXT      = 3'd5;

   logic [2:0]    state;
   logic [W-1:0]  seq;
   logic [TW-1:0] timer;
   logic [B-1:0]  rx;
   logic [W-1:0]  payload;
   logic          reply_bad;

   assign payload = SEED + seq;

   // A reply is good only if it came back from the echo node, addressed to us, with our payload.
   assign reply_bad = (rx[W-1:0] != payload) ||
                      (rx[B-1 -: AW] != ECHO_ADDR) ||
                      (rx[W +: AW] != MY_ADDR);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state           <= S_IDLE;
         seq             <= '0;
         timer           <= '0;
         rx              <= '0;
         din_o           <= '0;
         wr_o            <= 1'b0;
         rd_o            <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         err_count_o     <= 8'h00;
         timeout_count_o <= 8'h00;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  seq             <= '0;
                  err_count_o     <= 8'h00;
                  timeout_count_o <= 8'h00;
                  busy_o          <= 1'b1;
                  pass_o          <= 1'b0;
                  din_o           <= {MY_ADDR, ECHO_ADDR, SEED};
                  state           <= S_SEND_WAIT;
               end
            end
            S_SEND_WAIT: begin
               din_o <= {MY_ADDR, ECHO_ADDR, payload};
               if (!wait_i) begin
                  wr_o  <= 1'b1;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               wr_o  <= 1'b0;
               timer <= '0;
               state <= S_RECV;
            end
            S_RECV: begin
               if (nd_i) begin
                  rx    <= dout_i;
                  rd_o  <= 1'b1;
                  state <= S_CHECK;
               end else if (timer == TIMER_LAST) begin
                  err_count_o     <= sat_inc(err_count_o);
                  timeout_count_o <= sat_inc(timeout_count_o);
                  state           <= S_NEXT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_CHECK: begin
               rd_o <= 1'b0;
               if (reply_bad) begin
                  err_count_o <= sat_inc(err_count_o);
               end
               state <= S_NEXT;
            end
            S_NEXT: begin
               if (seq == SEQ_LAST) begin
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= (err_count_o == 8'h00);
                  state  <= S_IDLE;
               end else begin
                  seq   <= seq + 1'b1;
                  din_o <= {MY_ADDR, ECHO_ADDR, payload + W'(1)};
                  state <= S_SEND_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtsnoc_echo_tester.sv
// Bench for rtsnoc_echo_tester: a loopback echo node with per-packet faults and a payload scoreboard.
module tb_rtsnoc_echo_tester;

   localparam int          W      = 16;
   localparam int          AW     = 5;
   localparam int          B      = W + 2*AW;
   localparam int          NUM    = 4;
   localparam int          TMO    = 8;
   localparam logic [W-1:0]  SEED_V = 16'hFFFE;
   localparam logic [AW-1:0] MY_A   = 5'b1_0_010;
   localparam logic [AW-1:0] ECHO_A = 5'b0_1_101;

   logic         clk_i;
   logic         rst_i;
   logic [B-1:0] din_o;
   logic         wr_o;
   logic [B-1:0] dout_i;
   logic         nd_i;
   logic         rd_o;
   logic         wait_i;
   logic         start_i;
   logic         busy_o;
   logic         done_o;
   logic         pass_o;
   logic [7:0]   err_count_o;
   logic [7:0]   timeout_count_o;

   // kind: 0 good, 1 payload xor 1, 2 reply orig local xor 1, 3 reply dst local xor 1, 4 no reply
   int plan_kind [NUM];
   int plan_dly  [NUM];
   int n_vec;
   int n_fail;
   int cyc;
   int start_cyc;
   int stall_cyc;
   int pkt_seen;
   logic [W-1:0] exp_q [$];

   rtsnoc_echo_tester #(
      .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(W),
      .MY_X(1), .MY_Y(0), .MY_LOCAL(3'd2),
      .ECHO_X(0), .ECHO_Y(1), .ECHO_LOCAL(3'd5),
      .NUM_PKTS(NUM), .SEED(SEED_V), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .din_o(din_o), .wr_o(wr_o),
      .dout_i(dout_i), .nd_i(nd_i), .rd_o(rd_o), .wait_i(wait_i),
      .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .err_count_o(err_count_o), .timeout_count_o(timeout_count_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk_i);
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_wr"}, wr_o, 0);
      check({tag, "_rd"}, rd_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_pass"}, pass_o, 0);
      check({tag, "_din"}, din_o, 0);
      check({tag, "_err"}, err_count_o, 0);
      check({tag, "_tmo"}, timeout_count_o, 0);
   endtask

   // Echo node: replies to each write with orig/dst swapped, after plan_dly cycles, faulted per plan.
   initial begin : echo_model
      logic [B-1:0] rep;
      int cnt;
      bit pend, prev_wr, prev_rd, prev_busy;
      int last_wr;
      int exp_gap;
      nd_i = 1'b0;
      dout_i = '0;
      pend = 0; prev_wr = 0; prev_rd = 0; prev_busy = 0;
      cnt = 0; last_wr = 0; rep = '0; pkt_seen = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            pend = 0; prev_wr = 0; prev_rd = 0; prev_busy = 0;
            nd_i = 1'b0;
            exp_q.delete();
            pkt_seen = 0;
            continue;
         end
         if (busy_o && !prev_busy) begin
            exp_q.delete();
            for (int i = 0; i < NUM; i++) exp_q.push_back(SEED_V + W'(i));
            pkt_seen = 0;
         end
         if (prev_wr) check("wr_one_cycle", wr_o, 0);
         if (prev_rd) check("rd_one_cycle", rd_o, 0);
         if (rd_o) nd_i = 1'b0;
         if (wr_o) begin
            check("tx_header", din_o[B-1:W], {MY_A, ECHO_A});
            if (exp_q.size() == 0) check("extra_wr", 1, 0);
            else check("tx_payload", din_o[W-1:0], exp_q.pop_front());
            if (pkt_seen == 0) begin
               check("first_wr_latency", cyc - start_cyc, 2 + stall_cyc);
            end else if (pkt_seen < NUM) begin
               exp_gap = (plan_kind[pkt_seen-1] == 4) ? TMO + 3 : plan_dly[pkt_seen-1] + 4;
               check("wr_to_wr_gap", cyc - last_wr, exp_gap);
            end
            last_wr = cyc;
            rep = {din_o[W +: AW], din_o[W+AW +: AW], din_o[W-1:0]};
            if (pkt_seen < NUM) begin
               case (plan_kind[pkt_seen])
                  1: rep[0]    = ~rep[0];
                  2: rep[W+AW] = ~rep[W+AW];
                  3: rep[W]    = ~rep[W];
                  default: ;
               endcase
               if (plan_kind[pkt_seen] != 4) begin
                  pend = 1;
                  cnt = plan_dly[pkt_seen];
               end
            end
            pkt_seen++;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               dout_i = rep;
               nd_i = 1'b1;
               pend = 0;
            end
         end
         prev_wr = wr_o;
         prev_rd = rd_o;
         prev_busy = busy_o;
      end
   end

   task automatic plan_clean();
      for (int i = 0; i < NUM; i++) begin
         plan_kind[i] = 0;
         plan_dly[i] = $urandom_range(1, 6);
      end
   endtask

   task automatic run_test(input int stall, input bit mid_start);
      int exp_err, exp_tmo, dones;
      bit fin;
      logic [B-1:0] flit0;
      exp_err = 0; exp_tmo = 0; dones = 0; fin = 0;
      flit0 = {MY_A, ECHO_A, SEED_V};
      for (int i = 0; i < NUM; i++) begin
         if (plan_kind[i] != 0) exp_err++;
         if (plan_kind[i] == 4) exp_tmo++;
      end
      @(negedge clk_i);
      stall_cyc = stall;
      wait_i = (stall > 0);
      start_i = 1'b1;
      start_cyc = cyc;
      @(negedge clk_i);
      start_i = 1'b0;
      if (stall > 0) begin
         for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk_i);
            check("stall_wr", wr_o, 0);
            check("stall_din", din_o, flit0);
         end
         @(negedge clk_i);
         wait_i = 1'b0;
      end
      for (int t = 0; t < 2000 && !fin; t++) begin
         @(negedge clk_i);
         start_i = mid_start && (t == 5);
         if (done_o) dones++;
         if (!busy_o) fin = 1;
      end
      start_i = 1'b0;
      check("run_finished", fin, 1);
      check("done_pulses", dones, 1);
      check("err_count", err_count_o, exp_err);
      check("timeout_count", timeout_count_o, exp_tmo);
      check("pass", pass_o, exp_err == 0);
      check("all_sent", exp_q.size(), 0);
      @(negedge clk_i);
      check("done_clears", done_o, 0);
      repeat (3) @(negedge clk_i);
      check("err_holds", err_count_o, exp_err);
      check("pass_holds", pass_o, exp_err == 0);
   endtask

   initial begin : main
      bit seen;
      n_vec = 0; n_fail = 0;
      rst_i = 1'b0; start_i = 1'b0; wait_i = 1'b0;
      stall_cyc = 0; start_cyc = 0;
      plan_clean();
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;

      plan_clean();
      run_test(0, 0);

      plan_clean();
      plan_kind[2] = 1;
      run_test(10, 0);

      plan_clean();
      plan_kind[$urandom_range(0, NUM-1)] = 2;
      run_test(0, 0);

      plan_clean();
      plan_kind[0] = 4;
      run_test(0, 0);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM; i++) begin
            plan_kind[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            plan_dly[i] = $urandom_range(1, 6);
         end
         run_test(0, 1);
      end

      // Abort a run in RECV with an asynchronous reset, then run clean again.
      for (int i = 0; i < NUM; i++) begin
         plan_kind[i] = 0;
         plan_dly[i] = 6;
      end
      plan_clean();
      run_test(0, 0);
      for (int i = 0; i < NUM; i++) plan_dly[i] = 6;
      @(negedge clk_i);
      stall_cyc = 0;
      start_i = 1'b1;
      start_cyc = cyc;
      @(negedge clk_i);
      start_i = 1'b0;
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk_i);
         if (pkt_seen >= 1) seen = 1;
      end
      check("abort_first_wr_seen", seen, 1);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      check_reset_outputs("async_abort");
      @(negedge clk_i);
      check("abort_no_done", done_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      plan_clean();
      run_test(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
